// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the BCD display sequencer.
package calc_pkg;

    localparam int DEF_WIDTH = 27;
    localparam int DEF_NDIG  = 8;

    localparam logic [3:0] BLANK    = 4'hF;
    localparam logic [3:0] ERRGLYPH = 4'hE;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_EMIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/calc_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift the
// BCD register left one bit, pulling in the next operand bit at the bottom.
module calc_dd_step #(
    parameter int NDIG = 8
) (
    input  logic [4*(NDIG+1)-1:0] bcd_i,
    input  logic                  bit_i,
    output logic [4*(NDIG+1)-1:0] bcd_o
);
    import calc_pkg::*;

    localparam int BW = 4 * (NDIG + 1);

    logic [BW-1:0] adj;

    // Per-nibble add-3 correction followed by the one-bit shift.
    always_comb begin
        adj = '0;
        for (int i = 0; i < NDIG + 1; i++) begin
            if (bcd_i[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_i[i*4 +: 4] + 4'd3;
            end else begin
                adj[i*4 +: 4] = bcd_i[i*4 +: 4];
            end
        end
        // The top bit falls off; the extra overflow nibble can never reach 8.
        bcd_o = BW'({adj, bit_i});
    end

endmodule

// File: rtl/calc_disp_seq.sv
// Binary-to-display sequencer: converts an unsigned value to BCD by double
// dabble, then streams one digit code per cycle to the display, LSD first.
// Handshake: a request is taken when start=1 in a cycle where ready=1; start
// in any other cycle is dropped. wr marks each cycle where data/pos are valid,
// and done pulses for one cycle after the last digit.
module calc_disp_seq #(
    parameter int WIDTH = calc_pkg::DEF_WIDTH,
    parameter int NDIG  = calc_pkg::DEF_NDIG
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             err,
    output logic             ready,
    output logic             wr,
    output logic [3:0]       data,
    output logic [3:0]       pos,
    output logic             done
);
    import calc_pkg::*;

    localparam int BW = 4 * (NDIG + 1);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    POS_LAST = 4'(NDIG - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        pos_q, pos_d;
    logic              err_q, err_d;

    logic [BW-1:0]     bcd_step;
    logic              show_err;
    logic [3:0]        msd;
    logic [3:0]        digit;

    calc_dd_step #(.NDIG(NDIG)) u_step (
        .bcd_i (bcd_q),
        .bit_i (op_q[WIDTH-1]),
        .bcd_o (bcd_step)
    );

    // Next-state and datapath control for IDLE -> CONV -> EMIT -> DONE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = value;
                    err_d   = err;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = bcd_step;
                op_d  = {op_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    pos_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (pos_q == POS_LAST) begin
                    pos_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    pos_d = pos_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    // Digit selection, leading-zero blanking and error pattern for the outputs.
    always_comb begin
        show_err = err_q || (bcd_q[BW-1 -: 4] != 4'd0);
        msd      = '0;
        for (int i = 1; i < NDIG; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                msd = 4'(i);
            end
        end
        digit = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (pos_q == 4'(i)) begin
                digit = bcd_q[i*4 +: 4];
            end
        end
        ready = (state_q == ST_IDLE);
        wr    = (state_q == ST_EMIT);
        done  = (state_q == ST_DONE);
        data  = '0;
        pos   = '0;
        if (wr) begin
            pos = pos_q;
            if (show_err) begin
                data = (pos_q == 4'd0) ? ERRGLYPH : BLANK;
            end else if (pos_q > msd) begin
                data = BLANK;
            end else begin
                data = digit;
            end
        end
    end

endmodule

// File: doc/calc_disp_seq.md
CALC_DISP_SEQ -- requirements
Module: calc_disp_seq

Interface
REQ-001 Parameter WIDTH, default 27, binary operand width in bits.
REQ-002 Parameter NDIG, default 8, number of display positions.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clock edge).
REQ-005 start  input  1  request to display value; accepted only when ready=1.
REQ-006 value  input  WIDTH  unsigned binary to display, sampled at acceptance.
REQ-007 err  input  1  error request, sampled at acceptance; forces error pattern.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 wr  output  1  digit strobe; data/pos valid while high.
REQ-010 data  output  4  digit code: 0-9 digit, 4'hE error glyph, 4'hF blank.
REQ-011 pos  output  4  display position; 0 = least significant digit.
REQ-012 done  output  1  one-cycle pulse after last digit.

Function
REQ-013 FSM states IDLE, CONV, EMIT, DONE; no other reachable states.
REQ-014 IDLE: ready=1; start=1 latches value and err, clears BCD register (4*(NDIG+1) bits) and iteration counter, next state CONV.
REQ-015 start while ready=0 is ignored; no queuing.
REQ-016 CONV: exactly WIDTH cycles of double dabble: per cycle, add 3 to each BCD nibble >=5, then shift {BCD, operand} left one bit.
REQ-017 CONV exit after iteration WIDTH-1 to EMIT with pos counter=0.
REQ-018 Overflow: BCD nibble NDIG (9th digit) nonzero after CONV => error pattern.
REQ-019 Error pattern (latched err or overflow): pos 0 data=4'hE, pos 1..NDIG-1 data=4'hF.
REQ-020 Leading-zero blanking: positions above the most significant nonzero digit emit 4'hF; value 0 emits 0 at pos 0, blank elsewhere.
REQ-021 EMIT: wr=1 for exactly NDIG consecutive cycles, pos=0,1,...,NDIG-1 ascending, one digit per cycle.
REQ-022 After pos=NDIG-1 go to DONE; DONE asserts done=1 for one cycle, wr=0, then IDLE.
REQ-023 Latency: accept at edge T; wr high cycles T+WIDTH+1 .. T+WIDTH+NDIG; done at T+WIDTH+NDIG+1; ready at T+WIDTH+NDIG+2.
REQ-024 Outside EMIT: wr=0, data=0, pos=0.
REQ-025 pos never exceeds NDIG-1; no wrap during EMIT.

Reset
REQ-026 reset=0 at a rising edge: state IDLE, ready=1, wr=0, done=0, data=0, pos=0, BCD/operand/counters=0.
REQ-027 Reset mid-CONV or mid-EMIT aborts; no further wr, no done pulse; first post-reset cycle is IDLE.
REQ-028 reset has priority over start in the same cycle.

Structure
REQ-029 Package calc_pkg holds state enum, BLANK=4'hF, ERRGLYPH=4'hE, default WIDTH/NDIG constants.
REQ-030 One combinational sub-module calc_dd_step: one double-dabble iteration (add-3 and shift) over NDIG+1 nibbles.
REQ-031 No division or modulo operators in RTL.

Verification
REQ-032 value=12345, err=0 -> wr sequence data 5,4,3,2,1,F,F,F at pos 0..7, done 1 cycle later.
REQ-033 value=0 -> data 0 at pos 0, F at pos 1..7.
REQ-034 value=99_999_999 -> data 9 at all pos 0..7; value=100_000_000 -> E at pos 0, F at pos 1..7.
REQ-035 value=42, err=1 -> E at pos 0, F at pos 1..7.
REQ-036 start pulsed during CONV and EMIT -> ignored; exactly 8 wr cycles and one done per accepted start; latency per REQ-023 (first wr 28 cycles after accept).
REQ-037 reset=0 while EMIT at pos=3 -> next cycle wr=0, pos=0, ready=1, no done.
